// File: rtl/video_timing_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
// Shared video timing for the 256x240 display path. Both the sync generator
// and the framebuffer read the visible-area sizes from here so the two can
// never disagree about the raster geometry.
//
// Contents:
//   coord_t           9-bit unsigned beam coordinate type
//   H_* / V_*         raw porch, sync and visible sizes
//   H_SYNC_START/END, H_MAX, V_SYNC_START/END, V_MAX   derived positions
//   TIMING_OK         elaboration-time legality of the numbers above
// ---------------------------------------------------------------------------
package video_timing_pkg;

  localparam int COORD_W = 9;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_DISPLAY = 256;
  localparam int H_BACK    = 23;
  localparam int H_FRONT   = 7;
  localparam int H_SYNC    = 23;

  localparam int V_DISPLAY = 240;
  localparam int V_TOP     = 5;
  localparam int V_BOTTOM  = 14;
  localparam int V_SYNC    = 3;

  // Sync pulses sit right after the front porch; the back porch closes the
  // line/frame, so the counters wrap straight from back porch into display.
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int H_MAX        = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1;

  localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
  localparam int V_MAX        = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1;

  // Every field must be non-empty and both counters must fit in coord_t.
  localparam bit TIMING_OK =
      (H_DISPLAY >= 1) && (H_BACK >= 1) && (H_FRONT >= 1) && (H_SYNC >= 1) &&
      (V_DISPLAY >= 1) && (V_TOP >= 1) && (V_BOTTOM >= 1) && (V_SYNC >= 1) &&
      (H_MAX < (1 << COORD_W)) && (V_MAX < (1 << COORD_W));

endpackage

// File: rtl/hvsync_generator_if.sv
// ---------------------------------------------------------------------------
// hvsync_generator_if
// Beam position and sync bundle from the sync generator to its consumers.
//
// Signals:
//   hsync, vsync   registered sync pulses, active high
//   display_on     beam inside the visible 256x240 area
//   hpos, vpos     current beam coordinates
// Modports:
//   master   the sync generator (drives everything)
//   slave    pixel/framebuffer logic (reads everything)
// ---------------------------------------------------------------------------
interface hvsync_generator_if;
  import video_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   display_on;
  coord_t hpos;
  coord_t vpos;

  modport master (output hsync, vsync, display_on, hpos, vpos);
  modport slave  (input  hsync, vsync, display_on, hpos, vpos);

endinterface

// File: rtl/hvsync_generator_wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter
// Up-counter that runs 0..MAX and then returns to 0, advancing only while
// enable is high. wrap flags the enabled cycle on which count sits at MAX,
// i.e. the cycle whose edge takes it back to 0, so it can chain a second
// counter without extra latency.
//
// Ports:
//   clk      pixel clock
//   reset    synchronous, active low
//   enable   count this cycle
//   count    current value
//   wrap     enable && count == MAX (combinational)
// ---------------------------------------------------------------------------
module wrap_counter #(
  parameter int WIDTH = 9,
  parameter int MAX   = 308
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  assign wrap = enable && (count == MAX_V);

  // Reset beats both counting and wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/hvsync_generator.sv
// ---------------------------------------------------------------------------
// hvsync_generator
// Raster timing for a 256x240 display: a horizontal pixel counter, a vertical
// line counter stepped at each line end, registered sync pulses and a
// combinational visible-area flag.
//
// Ports:
//   clk     pixel clock, all state changes on its rising edge
//   reset   synchronous, active low
//   vid     hvsync_generator_if.master: hsync, vsync, display_on, hpos, vpos
// ---------------------------------------------------------------------------
module hvsync_generator
  import video_timing_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  hvsync_generator_if.master  vid
);

  localparam coord_t H_SYNC_START_C = COORD_W'(H_SYNC_START);
  localparam coord_t H_SYNC_END_C   = COORD_W'(H_SYNC_END);
  localparam coord_t V_SYNC_START_C = COORD_W'(V_SYNC_START);
  localparam coord_t V_SYNC_END_C   = COORD_W'(V_SYNC_END);
  localparam coord_t H_DISPLAY_C    = COORD_W'(H_DISPLAY);
  localparam coord_t V_DISPLAY_C    = COORD_W'(V_DISPLAY);

  // Refuse to build with timing that would overflow the coordinates or
  // collapse a porch/sync field to nothing.
  if (!TIMING_OK) begin : g_illegal_timing
    $fatal(1, "hvsync_generator: illegal video timing parameters");
  end

  coord_t hpos;
  coord_t vpos;
  logic   h_wrap;
  logic   v_wrap;
  logic   hsync_q;
  logic   vsync_q;

  wrap_counter #(.WIDTH(COORD_W), .MAX(H_MAX)) u_h_counter (
    .clk    (clk),
    .reset  (reset),
    .enable (1'b1),
    .count  (hpos),
    .wrap   (h_wrap)
  );

  // The line counter only moves on the last pixel of each line.
  wrap_counter #(.WIDTH(COORD_W), .MAX(V_MAX)) u_v_counter (
    .clk    (clk),
    .reset  (reset),
    .enable (h_wrap),
    .count  (vpos),
    .wrap   (v_wrap)
  );

  // A frame can only end on a line end.
  a_frame_end_on_line_end : assert property (
    @(posedge clk) disable iff (!reset) v_wrap |-> h_wrap
  );

  // Syncs are decoded from the current position and registered, so each
  // pulse appears one clock after the position that starts it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      hsync_q <= (hpos >= H_SYNC_START_C) && (hpos <= H_SYNC_END_C);
      vsync_q <= (vpos >= V_SYNC_START_C) && (vpos <= V_SYNC_END_C);
    end
  end

  assign vid.hpos       = hpos;
  assign vid.vpos       = vpos;
  assign vid.hsync      = hsync_q;
  assign vid.vsync      = vsync_q;
  assign vid.display_on = (hpos < H_DISPLAY_C) && (vpos < V_DISPLAY_C);

endmodule

// File: tb/tb_hvsync_generator.sv
// ---------------------------------------------------------------------------
// tb_hvsync_generator
// Bench for hvsync_generator. The expected raster is derived from the number
// of clocks elapsed since the last reset edge, using plain division and
// remainder over the line and frame lengths.
// ---------------------------------------------------------------------------
module tb_hvsync_generator;

  localparam int LINE_LEN   = 309;
  localparam int FRAME_LINES = 262;
  localparam int VIS_W      = 256;
  localparam int VIS_H      = 240;
  localparam int HS_FIRST   = 263;
  localparam int HS_LAST    = 285;
  localparam int VS_FIRST   = 254;
  localparam int VS_LAST    = 256;
  localparam int VS_CLOCKS  = 3 * LINE_LEN;

  typedef struct {
    longint     tick;
    logic [8:0] h;
    logic [8:0] v;
    logic       hs;
    logic       vs;
    logic       de;
  } exp_t;

  logic clk;
  logic reset;

  hvsync_generator_if vid ();

  hvsync_generator dut (
    .clk   (clk),
    .reset (reset),
    .vid   (vid.master)
  );

  exp_t   sb_q[$];
  int     vectors;
  int     miscompares;
  longint elapsed;
  bit     elapsed_valid;
  bit     stim_done;
  int     vs_run;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raster position after n clocks of free running since a reset edge.
  function automatic exp_t model(input longint n);
    exp_t   e;
    longint p;
    e.tick = n;
    e.h  = 9'(n % LINE_LEN);
    e.v  = 9'((n / LINE_LEN) % FRAME_LINES);
    e.de = (int'(e.h) < VIS_W) && (int'(e.v) < VIS_H);
    e.hs = 1'b0;
    e.vs = 1'b0;
    if (n >= 1) begin
      p = n - 1;
      e.hs = ((p % LINE_LEN) >= HS_FIRST) && ((p % LINE_LEN) <= HS_LAST);
      e.vs = (((p / LINE_LEN) % FRAME_LINES) >= VS_FIRST) &&
             (((p / LINE_LEN) % FRAME_LINES) <= VS_LAST);
    end
    return e;
  endfunction

  // Hold reset at rst_val for the given number of edges, queueing the raster
  // state the design should show after each edge.
  task automatic applyStimulus(input logic rst_val, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      reset = rst_val;
      @(posedge clk);
      #1;
      if (!rst_val) begin
        elapsed       = 0;
        elapsed_valid = 1'b1;
      end else if (elapsed_valid) begin
        elapsed = elapsed + 1;
      end
      if (elapsed_valid) sb_q.push_back(model(elapsed));
    end
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (vid.hpos !== e.h || vid.vpos !== e.v || vid.hsync !== e.hs ||
        vid.vsync !== e.vs || vid.display_on !== e.de) begin
      miscompares++;
      $display("[TB] FAIL raster n=%0d: got h=%0d v=%0d hs=%b vs=%b de=%b, want h=%0d v=%0d hs=%b vs=%b de=%b",
               e.tick, vid.hpos, vid.vpos, vid.hsync, vid.vsync, vid.display_on,
               e.h, e.v, e.hs, e.vs, e.de);
    end
  endtask

  // Monitor: compares whenever an expected state is pending, and measures
  // each complete vsync pulse.
  initial begin
    vs_run = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        checkOutput(sb_q.pop_front());
        if (vid.vsync === 1'b1) begin
          vs_run++;
        end else if (vs_run > 0) begin
          vectors++;
          if (vs_run != VS_CLOCKS) begin
            miscompares++;
            $display("[TB] FAIL vsync_width: got %0d clocks, want %0d", vs_run, VS_CLOCKS);
          end
          vs_run = 0;
        end
      end
    end
  end

  initial begin
    int waited;
    vectors       = 0;
    miscompares   = 0;
    elapsed       = 0;
    elapsed_valid = 1'b0;
    stim_done     = 1'b0;
    reset         = 1'b0;

    $display("[TB] start");
    applyStimulus(1'b0, 2);

    // Random runs broken by short resets, including mid-line and the
    // three-clock reset case.
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, int'($urandom_range(1, 500)));
      applyStimulus(1'b0, (k == 0) ? 3 : int'($urandom_range(1, 4)));
    end

    // Reset mid-line, then a full frame plus a little of the next.
    applyStimulus(1'b1, 137);
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, LINE_LEN * FRAME_LINES + 2 * LINE_LEN);
    stim_done = 1'b1;

    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (sb_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hvsync_generator.md
HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

Interface
REQ-001 H_DISPLAY, 256, visible pixels per line.
REQ-002 H_BACK, 23, left border (back porch) clocks.
REQ-003 H_FRONT, 7, right border (front porch) clocks.
REQ-004 H_SYNC, 23, horizontal sync width in clocks.
REQ-005 V_DISPLAY, 240, visible lines per frame.
REQ-006 V_TOP, 5, top border lines.
REQ-007 V_BOTTOM, 14, bottom border lines.
REQ-008 V_SYNC, 3, vertical sync width in lines.
REQ-009 clk  input  1  single pixel clock; all state changes on its rising edge.
REQ-010 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-011 hsync  output  1  registered horizontal sync, active high.
REQ-012 vsync  output  1  registered vertical sync, active high.
REQ-013 display_on  output  1  high while the beam is inside the visible area.
REQ-014 hpos  output  9  current horizontal position, unsigned.
REQ-015 vpos  output  9  current vertical position, unsigned.

Function
REQ-016 Derived constants SHALL be: H_SYNC_START=H_DISPLAY+H_FRONT (263), H_SYNC_END=H_SYNC_START+H_SYNC-1 (285), H_MAX=H_DISPLAY+H_BACK+H_FRONT+H_SYNC-1 (308).
REQ-017 Derived constants SHALL be: V_SYNC_START=V_DISPLAY+V_BOTTOM (254), V_SYNC_END=V_SYNC_START+V_SYNC-1 (256), V_MAX=V_DISPLAY+V_TOP+V_BOTTOM+V_SYNC-1 (261).
REQ-018 hpos SHALL increment by 1 every clock and wrap from H_MAX to 0 on the next clock.
REQ-019 vpos SHALL increment by 1 only on clocks where hpos==H_MAX; it SHALL wrap from V_MAX to 0 when hpos==H_MAX and vpos==V_MAX; otherwise it holds.
REQ-020 Line period SHALL be H_MAX+1 = 309 clocks; frame period SHALL be 309*262 = 80958 clocks.
REQ-021 hsync SHALL be registered from the current hpos: next hsync = (H_SYNC_START <= hpos <= H_SYNC_END), so hsync is high for exactly H_SYNC clocks, during the cycles where hpos is 264..286.
REQ-022 vsync SHALL be registered from the current vpos: next vsync = (V_SYNC_START <= vpos <= V_SYNC_END), so it is high for V_SYNC*309 clocks and lags the vpos transitions by one clock.
REQ-023 display_on SHALL be combinational: (hpos < H_DISPLAY) and (vpos < V_DISPLAY), with no added latency.
REQ-024 All comparisons SHALL be unsigned on 9 bits; the counters SHALL never reach values above H_MAX or V_MAX.
REQ-025 Parameter legality (H_MAX<512, V_MAX<512, every field >=1) SHALL be checked at elaboration, and elaboration SHALL fail on violation.

Reset
REQ-026 While reset==0 at a rising edge, hpos, vpos, hsync and vsync SHALL all become 0; display_on therefore reads 1.
REQ-027 Reset asserted mid-line or mid-frame SHALL take priority over counting and wrap; the first clock after release SHALL advance hpos to 1.
REQ-028 No initial-value dependence is permitted; the outputs are defined only after one reset clock.

Structure
REQ-029 Timing parameters and derived constants SHALL live in shared package video_timing_pkg, which the companion ram_async_tristate framebuffer block also imports.
REQ-030 One sub-module is natural: wrap_counter (parameterised width and max, enable input, wrap pulse output), instantiated once for h (enable=1) and once for v (enable=h wrap).
REQ-031 No tristate, latch or multi-clock logic is permitted in this block.

Verification
REQ-032 Reset held 0 for 3 clocks mid-frame, then released -> hpos=0, vpos=0, hsync=0, vsync=0 during reset; hpos=1 one clock after release.
REQ-033 Free-run one line from reset -> hpos reaches 308 and returns to 0 on the 309th clock; vpos steps 0->1 on the same edge.
REQ-034 Observe hsync over one line -> it rises on the edge after hpos==263, stays high for exactly 23 clocks, and falls on the edge after hpos==285.
REQ-035 Run a full frame -> vsync is high for 927 consecutive clocks starting on the edge after vpos becomes 254; vpos wraps 261->0 at clock 80958.
REQ-036 Sample display_on at the points (255,239), (256,0) and (0,240) -> reads 1, 0 and 0 respectively.
REQ-037 Two consecutive frames -> hsync and vsync patterns are identical and periodic, with no X on any output after reset.
